// File: rtl/serial_window_sampler.sv
// serial_window_sampler
//
// Front end for a 4-input pattern decoder. An asynchronous serial line is
// synchronised, sampled once every DIV clock cycles while enabled, and
// shifted into a 4-bit window presented as parallel bits.
//
// Parameters
//   DIV          sample period in clk cycles (1..256)
//   SYNC_STAGES  depth of the din synchroniser (2..4)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   din          asynchronous serial data
//   en           sampling enable (synchronous)
//   flush        synchronous clear of window, fill state and prescaler
//   a            oldest window bit (window[3])
//   b            window[2]
//   c            window[1]
//   d            newest window bit (window[0])
//   valid        window holds 4 samples taken since the last reset/flush
//   sample_tick  one-cycle pulse when a new sample becomes visible
module serial_window_sampler #(
  parameter int DIV         = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic en,
  input  logic flush,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic valid,
  output logic sample_tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [2:0] FILL_FULL = 3'd4;

  // ------------------------------------------------------------------
  // Input synchroniser
  // ------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   din_s;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= 1'b0;
          else        sync_reg[gi] <= din;
        end
      end else begin : g_rest
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= 1'b0;
          else        sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign din_s = sync_reg[SYNC_STAGES-1];

  // ------------------------------------------------------------------
  // Prescaler, window and fill state
  // ------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_reg,    cnt_next;
  logic [3:0]       window_reg, window_next;
  logic [2:0]       fill_reg,   fill_next;
  logic             valid_reg,  valid_next;
  logic             tick_reg,   tick_next;
  logic             tick;

  // flush masks the tick so a coincident sample is discarded.
  assign tick = en && !flush && (cnt_reg == CNT_LAST);

  always_comb begin
    cnt_next    = cnt_reg;
    window_next = window_reg;
    fill_next   = fill_reg;
    tick_next   = 1'b0;

    if (flush) begin
      cnt_next    = '0;
      window_next = 4'b0000;
      fill_next   = 3'd0;
    end else if (en) begin
      cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CNT_W'(1);
      if (tick) begin
        window_next = {window_reg[2:0], din_s};
        tick_next   = 1'b1;
        if (fill_reg != FILL_FULL) fill_next = fill_reg + 3'd1;
      end
    end else begin
      // Disabling discards any partial period.
      cnt_next = '0;
    end

    // Derived from the next fill so valid rises together with the 4th tick.
    valid_next = (fill_next == FILL_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      window_reg <= 4'b0000;
      fill_reg   <= 3'd0;
      valid_reg  <= 1'b0;
      tick_reg   <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      window_reg <= window_next;
      fill_reg   <= fill_next;
      valid_reg  <= valid_next;
      tick_reg   <= tick_next;
    end
  end

  assign a           = window_reg[3];
  assign b           = window_reg[2];
  assign c           = window_reg[1];
  assign d           = window_reg[0];
  assign valid       = valid_reg;
  assign sample_tick = tick_reg;

endmodule

// File: doc/serial_window_sampler.md
# serial_window_sampler

Front-end stage that feeds the 4-input pattern decoder. Synchronises an asynchronous serial line, samples it at a programmable rate, and shifts the samples into a 4-bit window. The window is presented as parallel bits a (oldest) to d (newest), together with a valid flag. The downstream decoder's output o=~a&b&c&d therefore flags the serial sequence 0,1,1,1 only while valid is high.

## Interface
- DIV, default 4: sample period in clk cycles; legal range 1..256.
- SYNC_STAGES, default 2: depth of the din synchroniser; legal range 2..4.
- clk  input  1  rising-edge clock for the whole block.
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronous to clk.
- din  input  1  asynchronous serial data.
- en  input  1  sampling enable; synchronous.
- flush  input  1  synchronous clear of the window and the fill state.
- a  output  1  oldest bit in the window (window[3]).
- b  output  1  window[2].
- c  output  1  window[1].
- d  output  1  newest bit in the window (window[0]).
- valid  output  1  high when the window holds 4 samples taken since the last reset or flush.
- sample_tick  output  1  one-cycle pulse on the cycle a sample is shifted in.

## Operation
- Synchroniser: din passes through SYNC_STAGES flops; din_s is the last stage.
- Prescaler: cnt, width max(1,$clog2(DIV)).
  - When en=1: cnt counts 0..DIV-1 and wraps to 0.
  - Tick condition: en=1 and cnt==DIV-1. With DIV=1 every en=1 cycle is a tick.
  - When en=0: cnt is forced to 0. window and fill hold their values.
- Shift on tick: window <= {window[2:0], din_s}.
- Fill counter: fill is 3 bits and saturates at 4. It increments on each tick while fill<4.
- valid = (fill==4). valid is registered and derived from fill.
- a, b, c, d are driven directly from the window register, with no combinational path from din.
- flush=1 takes priority over en and over the tick. On the next edge, window, fill and cnt clear to 0 and no shift happens. sample_tick is 0 in a flush cycle.
- Reset (rst_n=0, asynchronous, any time including mid-fill):
  - synchroniser flops, window, fill and cnt all go to 0.
  - outputs a=b=c=d=0, valid=0, sample_tick=0.

## Timing
- A din edge reaches din_s SYNC_STAGES cycles later.
- The first tick comes DIV cycles after en rises, counting from cnt=0.
- sample_tick is registered and asserts in the same cycle that the window update becomes visible.
- valid rises in the same cycle as the 4th sample_tick after reset or flush. It stays high until flush or reset; later ticks keep it high.
- Steady state: one new window every DIV cycles. The downstream decoder sees each window for exactly DIV cycles while en=1.
- en dropping mid-period discards the partial count. The next tick comes DIV cycles after en returns high.
- flush and tick in the same cycle: flush wins and the sample is discarded.
- Decoder result for window N is valid combinationally during the cycles that window N is held.

## Test plan
- Reset: with rst_n=0 toggle din/en/flush randomly, then release. Required: a..d=0, valid=0, sample_tick=0 until the first tick. The first tick is DIV+SYNC_STAGES-aligned.
- Fill and pattern, DIV=4, SYNC_STAGES=2:
  - Stimulus: en=1, and din held at 0,1,1,1 for 4 cycles each, aligned to ticks.
  - Required: sample_tick every 4 cycles, and valid rises on the 4th tick.
  - Required: {a,b,c,d}=0111 in that cycle, so the downstream o=1.
- Sliding window: continue with din=1 for one more period. Required: {a,b,c,d}=1111, valid stays 1, o=0.
- en gap:
  - Stimulus: drop en for 7 cycles after 2 ticks, then raise it.
  - Required: no ticks during the gap, and window/fill are held.
  - Required: the next tick comes 4 cycles after en returns, and valid rises at the 4th cumulative tick.
- Flush priority: assert flush on a tick cycle with valid=1. Required next cycle: window=0000, valid=0, sample_tick=0. Refill needs 4 new ticks.
- DIV=1 corner: en=1, din pattern 0,1,1,1 one bit per cycle. Required: sample_tick high every cycle, and valid plus {a,b,c,d}=0111 exactly SYNC_STAGES+4 cycles after the first bit.
